// File: rtl/circle_raster_engine.sv
`default_nettype none
// ============================================================================
// Module      : circle_raster_engine
// Description : Midpoint-circle rasteriser. It emits one candidate pixel per
//               cycle in outline or filled mode and clips off-screen pixels
//               by dropping vga_plot. Clipping does not change the timing.
// Revision    : 1.0 - initial release
// ============================================================================
module circle_raster_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int R_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [R_W-1:0]      radius,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                fill,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_init   = 3'd1;
    localparam logic [2:0] c_plot   = 3'd2;
    localparam logic [2:0] c_update = 3'd3;
    localparam logic [2:0] c_done   = 3'd4;

    localparam logic        [X_W+1:0] c_scr_w = SCREEN_W[X_W+1:0];
    localparam logic        [Y_W+1:0] c_scr_h = SCREEN_H[Y_W+1:0];
    localparam logic signed [R_W:0]   c_one_o = 1;
    localparam logic signed [R_W+2:0] c_one_c = 1;

    logic [2:0]               r_state;
    logic [X_W-1:0]           r_cx;
    logic [Y_W-1:0]           r_cy;
    logic [R_W-1:0]           r_r;
    logic [COLOUR_W-1:0]      r_colour;
    logic                     r_fill;
    logic signed [R_W:0]      r_ox;
    logic signed [R_W:0]      r_oy;
    logic signed [R_W+2:0]    r_crit;
    logic [2:0]               r_sub;   // octant index (outline) or span index (fill)
    logic signed [R_W:0]      r_dx;    // running x offset inside a fill span

    logic signed [R_W:0]      w_off_x;
    logic signed [R_W:0]      w_off_y;
    logic signed [R_W:0]      w_sel_x;
    logic signed [R_W:0]      w_sel_y;
    logic                     w_neg_x;
    logic                     w_neg_y;
    logic signed [X_W+1:0]    w_x;
    logic signed [Y_W+1:0]    w_y;
    logic                     w_x_on;
    logic                     w_y_on;
    logic signed [R_W:0]      w_span_w;
    logic signed [R_W:0]      w_next_w;
    logic                     w_span_end;
    logic signed [R_W:0]      w_oy_n;
    logic signed [R_W:0]      w_ox_n;
    logic                     w_dec;
    logic signed [R_W+2:0]    w_oy_c;
    logic signed [R_W+2:0]    w_ox_c;
    logic signed [R_W+2:0]    w_diff;
    logic signed [R_W+2:0]    w_crit_n;
    logic                     w_fin;

    // Offset selection for the current candidate pixel, then signed coordinates and clipping
    always_comb begin
        if (r_fill) begin
            w_sel_x = r_dx;
            w_neg_x = 1'b0;
            w_sel_y = r_sub[1] ? r_ox : r_oy;
            w_neg_y = r_sub[0];
        end else begin
            w_sel_x = r_sub[0] ? r_oy : r_ox;
            w_neg_x = r_sub[2] ^ r_sub[1];
            w_sel_y = r_sub[0] ? r_ox : r_oy;
            w_neg_y = r_sub[2];
        end
        w_off_x = w_neg_x ? -w_sel_x : w_sel_x;
        w_off_y = w_neg_y ? -w_sel_y : w_sel_y;
        w_x = {2'b00, r_cx} + {{(X_W+1-R_W){w_off_x[R_W]}}, w_off_x};
        w_y = {2'b00, r_cy} + {{(Y_W+1-R_W){w_off_y[R_W]}}, w_off_y};
        w_x_on = !w_x[X_W+1] && ({1'b0, w_x[X_W:0]} < c_scr_w);
        w_y_on = !w_y[Y_W+1] && ({1'b0, w_y[Y_W:0]} < c_scr_h);
    end

    // Fill span bookkeeping: spans 0/1 are ox wide, spans 2/3 are oy wide
    always_comb begin
        w_span_w   = r_sub[1] ? r_oy : r_ox;
        w_next_w   = (r_sub[1:0] == 2'd0) ? r_ox : r_oy;
        w_span_end = (r_dx == w_span_w);
    end

    // Midpoint step: advance oy, maybe retreat ox, update the decision term with the new values
    always_comb begin
        w_dec    = !(r_crit[R_W+2] || (r_crit == '0));
        w_oy_n   = r_oy + c_one_o;
        w_ox_n   = w_dec ? (r_ox - c_one_o) : r_ox;
        w_oy_c   = {{2{w_oy_n[R_W]}}, w_oy_n};
        w_ox_c   = {{2{w_ox_n[R_W]}}, w_ox_n};
        w_diff   = w_dec ? (w_oy_c - w_ox_c) : w_oy_c;
        w_crit_n = r_crit + w_diff + w_diff + c_one_c;
        w_fin    = (w_oy_n > w_ox_n);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_idle;
            r_cx     <= '0;
            r_cy     <= '0;
            r_r      <= '0;
            r_colour <= '0;
            r_fill   <= 1'b0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_crit   <= '0;
            r_sub    <= '0;
            r_dx     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_cx     <= centre_x;
                        r_cy     <= centre_y;
                        r_r      <= radius;
                        r_colour <= colour_in;
                        r_fill   <= fill;
                        r_state  <= c_init;
                    end
                end
                c_init: begin
                    r_ox    <= {1'b0, r_r};
                    r_oy    <= '0;
                    r_crit  <= c_one_c - {3'b000, r_r};
                    r_dx    <= -{1'b0, r_r};
                    r_sub   <= '0;
                    r_state <= c_plot;
                end
                c_plot: begin
                    if (!r_fill) begin
                        r_sub <= r_sub + 3'd1;
                        if (r_sub == 3'd7) begin
                            r_state <= c_update;
                        end
                    end else if (w_span_end) begin
                        if (r_sub[1:0] == 2'd3) begin
                            r_state <= c_update;
                        end else begin
                            r_sub <= r_sub + 3'd1;
                            r_dx  <= -w_next_w;
                        end
                    end else begin
                        r_dx <= r_dx + c_one_o;
                    end
                end
                c_update: begin
                    r_oy    <= w_oy_n;
                    r_ox    <= w_ox_n;
                    r_crit  <= w_crit_n;
                    r_sub   <= '0;
                    r_dx    <= -w_ox_n;
                    r_state <= w_fin ? c_done : c_plot;
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Output decode from state and registers
    always_comb begin
        busy       = (r_state != c_idle);
        done       = (r_state == c_done);
        vga_colour = r_colour;
        vga_plot   = (r_state == c_plot) && w_x_on && w_y_on;
        vga_x      = (r_state == c_plot) ? w_x[X_W-1:0] : '0;
        vga_y      = (r_state == c_plot) ? w_y[Y_W-1:0] : '0;
    end

endmodule
`default_nettype wire
